// File: rtl/pll_mgmt_pkg.sv
// Shared definitions for the PLL management responder: register map,
// FSM state codes and the counter-word divider decode.
package pll_mgmt_pkg;

  // Register map
  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_APPLY = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C0    = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;
  localparam logic [5:0] ADDR_BW    = 6'd8;
  localparam logic [5:0] ADDR_CP    = 6'd9;

  // FSM state codes
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t BUSY   = 2'd1;
  localparam state_t RELOCK = 2'd2;

  // Counter word -> divide ratio. Bit 16 bypasses the counter, bit 17
  // (odd duty) only shapes the waveform, and hi=lo=0 means the full 256.
  function automatic logic [8:0] div_decode(input logic [17:0] w);
    logic [8:0] sum;
    sum = {1'b0, w[15:8]} + {1'b0, w[7:0]};
    if (w[16]) begin
      div_decode = 9'd1;
    end else if (sum == 9'd0) begin
      div_decode = 9'd256;
    end else begin
      div_decode = sum;
    end
  endfunction

endpackage

// File: rtl/pll_cnt_decode.sv
// Combinational decode of one 18-bit PLL counter word into its divide ratio.
module pll_cnt_decode
  import pll_mgmt_pkg::*;
(
  input  logic [17:0] word,
  output logic [8:0]  ratio
);

  assign ratio = div_decode(word);

endmodule

// File: rtl/pll_mgmt_responder.sv
// Avalon-MM management slave for PLL reconfiguration. Writes land in shadow
// registers; a write to the apply register stalls the bus for a fixed busy
// window, then commits every shadow to the cfg_* outputs in one cycle and
// holds locked low for the relock window.
module pll_mgmt_responder
  import pll_mgmt_pkg::*;
#(
  parameter int unsigned APPLY_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES  = 64,
  parameter logic [17:0] DEF_M        = 18'h00404,
  parameter logic [17:0] DEF_N        = 18'h10000,
  parameter logic [17:0] DEF_C0       = 18'h00202,
  parameter logic [31:0] DEF_K        = 32'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  input  logic        mgmt_read,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic        locked,
  output logic [17:0] cfg_m_raw,
  output logic [17:0] cfg_n_raw,
  output logic [17:0] cfg_c0_raw,
  output logic [31:0] cfg_k,
  output logic [3:0]  cfg_bw,
  output logic [2:0]  cfg_cp,
  output logic [8:0]  cfg_m_div,
  output logic [8:0]  cfg_n_div,
  output logic [8:0]  cfg_c0_div,
  output logic        cfg_commit
);

  localparam int unsigned CNT_MAX = (APPLY_CYCLES > LOCK_CYCLES) ? APPLY_CYCLES : LOCK_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] APPLY_LOAD = CNT_W'(APPLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic        mode_q;
  logic [17:0] n_q;
  logic [17:0] m_q;
  logic [17:0] c0_q;
  logic [31:0] k_q;
  logic [3:0]  bw_q;
  logic [2:0]  cp_q;

  logic        accept_wr;
  logic        accept_rd;
  logic        apply_hit;
  logic [31:0] rd_mux;

  // The bus stalls while reset is held and for the whole busy window.
  assign mgmt_waitrequest = reset || (state == BUSY);

  // Write has priority: a simultaneous read is simply not accepted.
  assign accept_wr = mgmt_write && !mgmt_waitrequest;
  assign accept_rd = mgmt_read && !mgmt_write && !mgmt_waitrequest;
  assign apply_hit = accept_wr && (mgmt_address == ADDR_APPLY);

  // Shadow register file: keeps only the implemented bits of each write.
  always_ff @(posedge clk) begin
    // NOTE: the shadows are a handful of flops, not a RAM, so each one takes
    // a reset value; a real memory array would be left unreset.
    if (reset) begin
      mode_q <= 1'b0;
      n_q    <= DEF_N;
      m_q    <= DEF_M;
      c0_q   <= DEF_C0;
      k_q    <= DEF_K;
      bw_q   <= 4'd7;
      cp_q   <= 3'd1;
    end else if (accept_wr) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      case (mgmt_address)
        ADDR_MODE: mode_q <= mgmt_writedata[0];
        ADDR_N:    n_q    <= mgmt_writedata[17:0];
        ADDR_M:    m_q    <= mgmt_writedata[17:0];
        ADDR_C0:   c0_q   <= mgmt_writedata[17:0];
        ADDR_K:    k_q    <= mgmt_writedata;
        ADDR_BW:   bw_q   <= mgmt_writedata[3:0];
        ADDR_CP:   cp_q   <= mgmt_writedata[2:0];
        default:   ;
      endcase
    end
  end

  // Apply sequencer: busy window, atomic commit, then relock window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      locked     <= 1'b1;
      cfg_commit <= 1'b0;
      cfg_m_raw  <= DEF_M;
      cfg_n_raw  <= DEF_N;
      cfg_c0_raw <= DEF_C0;
      cfg_k      <= DEF_K;
      cfg_bw     <= 4'd7;
      cfg_cp     <= 3'd1;
    end else begin
      cfg_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (apply_hit) begin
            state  <= BUSY;
            cnt    <= APPLY_LOAD;
            locked <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            cfg_m_raw  <= m_q;
            cfg_n_raw  <= n_q;
            cfg_c0_raw <= c0_q;
            cfg_k      <= k_q;
            cfg_bw     <= bw_q;
            cfg_cp     <= cp_q;
            cfg_commit <= 1'b1;
            cnt        <= LOCK_LOAD;
            state      <= RELOCK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELOCK: begin
          if (apply_hit) begin
            state <= BUSY;
            cnt   <= APPLY_LOAD;
          end else if (cnt == '0) begin
            locked <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux over the shadows; unimplemented bits and addresses read as 0.
  always_comb begin
    // NOTE: default first so no path through the case leaves rd_mux
    // unassigned, which would infer a latch.
    rd_mux = '0;
    case (mgmt_address)
      ADDR_MODE: rd_mux = {31'b0, mode_q};
      ADDR_N:    rd_mux = {14'b0, n_q};
      ADDR_M:    rd_mux = {14'b0, m_q};
      ADDR_C0:   rd_mux = {14'b0, c0_q};
      ADDR_K:    rd_mux = k_q;
      ADDR_BW:   rd_mux = {28'b0, bw_q};
      ADDR_CP:   rd_mux = {29'b0, cp_q};
      default:   rd_mux = '0;
    endcase
  end

  assign mgmt_readdata = accept_rd ? rd_mux : 32'd0;

  pll_cnt_decode u_dec_m  (.word(cfg_m_raw),  .ratio(cfg_m_div));
  pll_cnt_decode u_dec_n  (.word(cfg_n_raw),  .ratio(cfg_n_div));
  pll_cnt_decode u_dec_c0 (.word(cfg_c0_raw), .ratio(cfg_c0_div));

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Self-checking bench for pll_mgmt_responder: directed scenarios plus a
// randomized register-access phase, all checked against a register-map model.
module tb_pll_mgmt_responder;

  localparam int APPLY = 16;
  localparam int LOCK  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        locked;
  logic [17:0] cfg_m_raw, cfg_n_raw, cfg_c0_raw;
  logic [31:0] cfg_k;
  logic [3:0]  cfg_bw;
  logic [2:0]  cfg_cp;
  logic [8:0]  cfg_m_div, cfg_n_div, cfg_c0_div;
  logic        cfg_commit;

  always #5 clk = ~clk;

  pll_mgmt_responder #(
    .APPLY_CYCLES(APPLY),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mgmt_address    (mgmt_address),
    .mgmt_write      (mgmt_write),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_read       (mgmt_read),
    .mgmt_readdata   (mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .locked          (locked),
    .cfg_m_raw       (cfg_m_raw),
    .cfg_n_raw       (cfg_n_raw),
    .cfg_c0_raw      (cfg_c0_raw),
    .cfg_k           (cfg_k),
    .cfg_bw          (cfg_bw),
    .cfg_cp          (cfg_cp),
    .cfg_m_div       (cfg_m_div),
    .cfg_n_div       (cfg_n_div),
    .cfg_c0_div      (cfg_c0_div),
    .cfg_commit      (cfg_commit)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: register contents indexed by address.
  logic [31:0] shadow    [0:15];
  logic [31:0] committed [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_mask(input int a);
    case (a)
      0:       return 32'h1;
      3, 4, 5: return 32'h3FFFF;
      7:       return 32'hFFFFFFFF;
      8:       return 32'hF;
      9:       return 32'h7;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (reg_mask(a) == 0) return 32'h0;
    return shadow[a % 16];
  endfunction

  // Divide ratio computed arithmetically from the counter word fields.
  function automatic logic [31:0] ref_ratio(input logic [31:0] w);
    int hi, lo;
    if (((w >> 16) & 1) == 1) return 32'd1;
    hi = int'((w >> 8) & 32'hFF);
    lo = int'(w & 32'hFF);
    if (hi + lo == 0) return 32'd256;
    return 32'(hi + lo);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    shadow[3] = 32'h10000;
    shadow[4] = 32'h00404;
    shadow[5] = 32'h00202;
    shadow[7] = 32'h1;
    shadow[8] = 32'h7;
    shadow[9] = 32'h1;
    for (int i = 0; i < 16; i++) committed[i] = shadow[i];
  endtask

  task automatic model_commit();
    for (int i = 0; i < 16; i++) committed[i] = shadow[i];
  endtask

  task automatic check_cfg(input string pfx);
    check({pfx, "_m_raw"},  32'(cfg_m_raw),  committed[4]);
    check({pfx, "_n_raw"},  32'(cfg_n_raw),  committed[3]);
    check({pfx, "_c0_raw"}, 32'(cfg_c0_raw), committed[5]);
    check({pfx, "_k"},      cfg_k,           committed[7]);
    check({pfx, "_bw"},     32'(cfg_bw),     committed[8]);
    check({pfx, "_cp"},     32'(cfg_cp),     committed[9]);
    check({pfx, "_m_div"},  32'(cfg_m_div),  ref_ratio(committed[4]));
    check({pfx, "_n_div"},  32'(cfg_n_div),  ref_ratio(committed[3]));
    check({pfx, "_c0_div"}, 32'(cfg_c0_div), ref_ratio(committed[5]));
  endtask

  // Present a write, hold it while stalled, and return the stall count.
  task automatic bus_write(input int a, input logic [31:0] d, output int waited);
    mgmt_address   = 6'(a);
    mgmt_writedata = d;
    mgmt_write     = 1'b1;
    waited         = 0;
    @(negedge clk);
    while (mgmt_waitrequest && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (mgmt_waitrequest) check("write_stall_timeout", 32'(mgmt_waitrequest), 32'h0);
    else if (reg_mask(a) != 0) shadow[a % 16] = d & reg_mask(a);
    @(posedge clk);
    #1 mgmt_write = 1'b0;
  endtask

  task automatic bus_read(input int a, input string tag);
    int waited;
    mgmt_address = 6'(a);
    mgmt_read    = 1'b1;
    waited       = 0;
    @(negedge clk);
    while (mgmt_waitrequest && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check(tag, mgmt_readdata, model_read(a));
    @(posedge clk);
    #1 mgmt_read = 1'b0;
  endtask

  task automatic bus_both(input int a, input logic [31:0] d, input string tag);
    mgmt_address   = 6'(a);
    mgmt_writedata = d;
    mgmt_write     = 1'b1;
    mgmt_read      = 1'b1;
    @(negedge clk);
    check(tag, mgmt_readdata, 32'h0);
    if (!mgmt_waitrequest && reg_mask(a) != 0) shadow[a % 16] = d & reg_mask(a);
    @(posedge clk);
    #1;
    mgmt_write = 1'b0;
    mgmt_read  = 1'b0;
  endtask

  // Apply and watch the whole busy + relock window cycle by cycle.
  task automatic do_apply(input string pfx);
    int waited, wr_hi, commits, commit_k, lock_k;
    logic [31:0] old_m;
    old_m = committed[4];
    bus_write(2, $urandom, waited);
    check({pfx, "_apply_wait"}, 32'(waited), 32'h0);
    model_commit();
    wr_hi = 0; commits = 0; commit_k = -1; lock_k = -1;
    for (int k = 1; k <= APPLY + LOCK + 4; k++) begin
      @(negedge clk);
      if (mgmt_waitrequest) wr_hi++;
      if (cfg_commit) begin
        commits++;
        if (commit_k < 0) commit_k = k;
      end
      if (locked && lock_k < 0) lock_k = k;
      if (k == APPLY) check({pfx, "_m_before_commit"}, 32'(cfg_m_raw), old_m);
    end
    check({pfx, "_busy_cycles"}, 32'(wr_hi), 32'(APPLY));
    check({pfx, "_commit_count"}, 32'(commits), 32'h1);
    check({pfx, "_commit_edge"}, 32'(commit_k), 32'(APPLY + 1));
    check({pfx, "_lock_edge"}, 32'(lock_k), 32'(APPLY + LOCK + 1));
    check_cfg(pfx);
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!locked && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(locked), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, commits, n;
    int a;
    logic [31:0] d;

    reset = 1'b1;
    mgmt_address = '0; mgmt_write = 1'b0; mgmt_writedata = '0; mgmt_read = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_waitrequest", 32'(mgmt_waitrequest), 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1. Reset state
    @(negedge clk);
    check("idle_waitrequest", 32'(mgmt_waitrequest), 32'h0);
    check("reset_locked", 32'(locked), 32'h1);
    check("reset_commit", 32'(cfg_commit), 32'h0);
    check("idle_readdata", mgmt_readdata, 32'h0);
    check("reset_m_div_8", 32'(cfg_m_div), 32'd8);
    check_cfg("reset");
    bus_read(4, "read_m_default");
    bus_read(2, "read_apply_zero");
    bus_read(0, "read_mode_default");

    // 2. Program M/C0/K and apply
    bus_write(4, 32'h20504, waited);
    bus_write(5, 32'h00202, waited);
    bus_write(7, 32'h1EB851EC, waited);
    do_apply("apply1");
    check("apply1_m_div_9", 32'(cfg_m_div), 32'd9);
    check("apply1_c0_div_4", 32'(cfg_c0_div), 32'd4);
    check("apply1_k", cfg_k, 32'h1EB851EC);

    // 3. Write held through BUSY lands on the first free cycle
    bus_write(2, 32'h0, waited);
    model_commit();
    bus_write(3, 32'h00303, waited);
    check("held_write_stall", 32'(waited), 32'(APPLY));
    check("held_n_raw_unchanged", 32'(cfg_n_raw), committed[3]);
    wait_lock("held_relock");
    check("held_n_raw_after_lock", 32'(cfg_n_raw), committed[3]);
    bus_read(3, "held_n_shadow");

    // 4. Unmapped address, width truncation, write-wins
    bus_write(6, 32'hFFFFFFFF, waited);
    bus_read(6, "read_unmapped");
    bus_write(8, 32'hFF, waited);
    bus_read(8, "read_bw_trunc");
    bus_both(9, 32'h5, "both_readdata");
    bus_read(9, "read_cp_after_both");
    bus_write(0, 32'hFFFFFFFF, waited);
    bus_read(0, "read_mode_trunc");

    // 5. Divider boundaries
    bus_write(4, 32'h00000, waited);
    do_apply("apply_m0");
    check("m_div_256", 32'(cfg_m_div), 32'd256);
    bus_write(4, 32'h10505, waited);
    do_apply("apply_bypass");
    check("m_div_bypass", 32'(cfg_m_div), 32'd1);

    // Apply during RELOCK restarts BUSY and keeps locked low
    bus_write(4, 32'h00A05, waited);
    bus_write(2, 32'h0, waited);
    model_commit();
    repeat (APPLY + 4) @(negedge clk);
    check("relock_locked_low", 32'(locked), 32'h0);
    bus_write(5, 32'h0FF01, waited);
    do_apply("apply_relock");

    // 6. Reset in the middle of BUSY
    bus_write(4, 32'h00707, waited);
    bus_write(2, 32'h0, waited);
    commits = 0;
    repeat (5) begin
      @(negedge clk);
      if (cfg_commit) commits++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midbusy_reset_wait", 32'(mgmt_waitrequest), 32'h1);
      if (cfg_commit) commits++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < APPLY + 4; k++) begin
      @(negedge clk);
      if (cfg_commit) commits++;
    end
    check("midbusy_no_commit", 32'(commits), 32'h0);
    check("midbusy_locked", 32'(locked), 32'h1);
    check("midbusy_wait_low", 32'(mgmt_waitrequest), 32'h0);
    check_cfg("midbusy");
    bus_read(4, "midbusy_m_shadow");
    bus_write(4, 32'h20504, waited);
    do_apply("apply_after_reset");

    // Randomized register traffic with periodic applies
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(0, 2));
      a = int'($urandom_range(0, 15));
      d = $urandom;
      if (i % 13 == 12) begin
        do_apply("rand_apply");
      end else if (n == 0) begin
        if (a == 2) a = 4;
        bus_write(a, d, waited);
      end else if (n == 1) begin
        if ($urandom_range(0, 3) == 0) a = int'($urandom_range(10, 63));
        bus_read(a, "rand_read");
      end else begin
        if (a == 2) a = 7;
        bus_both(a, d, "rand_both");
      end
    end
    for (int a2 = 0; a2 < 16; a2++) bus_read(a2, "final_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
